mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/arb_wait_counter.sv | 33 +++
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core/host memory arbiter: read-owner state
// encoding and default starvation limit.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        HOST_RD = 2'd2
    } owner_e;

    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W       = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear; tracks how long the host
// has been held off so it can be forced through at the limit.
module arb_wait_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q < MAX_V)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q >= MAX_V);
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port 1-cycle-latency memory. Core has
// priority; the host wins once it has waited MAX_WAIT contended cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    owner_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              starved;
    logic              h_wait;

    // Grants are masked during reset so a request can't reach memory.
    assign c_gnt  = !reset && c_req && !(h_req && starved);
    assign h_gnt  = !reset && h_req && (!c_req || starved);
    assign h_wait = h_req && !h_gnt;

    arb_wait_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) u_wait (
        .clk_i (CLK),
        .rst_i (reset),
        .inc_i (h_wait),
        .clr_i (!h_wait),
        .cnt_o (wait_cnt),
        .sat_o (starved)
    );

    always_comb begin
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
        if (c_gnt) begin
            m_addr  = c_addr;
            m_we    = c_we;
            m_wdata = c_wdata;
        end else if (h_gnt) begin
            m_addr  = h_addr;
            m_we    = h_we;
            m_wdata = h_wdata;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (c_gnt && !c_we)
            state_d = CORE_RD;
        else if (h_gnt && !h_we)
            state_d = HOST_RD;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign c_rvalid = (state_q == CORE_RD);
    assign h_rvalid = (state_q == HOST_RD);
    assign c_rdata  = m_rdata;
    assign h_rdata  = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences
// and random traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          CLK = 1'b0;
    logic          reset;
    logic          c_req, c_we, h_req, h_we;
    logic [AW-1:0] c_addr, h_addr, m_addr;
    logic [DW-1:0] c_wdata, h_wdata, m_wdata, m_rdata, c_rdata, h_rdata;
    logic          c_gnt, c_rvalid, h_gnt, h_rvalid, m_we;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Environment memory: single port, registered read.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge CLK) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    // Reference model state: shadow memory, host wait length, outstanding read.
    logic [DW-1:0] mm [1<<AW];
    int            waits;
    bit            pend_v;
    bit            pend_host;
    logic [DW-1:0] pend_data;
    bit            g_c, g_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    endtask

    // Called #1 into a low clock phase; compares outputs against the model.
    task automatic mcheck(input string tag);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        g_c = !reset && c_req && (!h_req || waits < MW);
        g_h = !reset && h_req && (!c_req || waits >= MW);
        ea = '0; ed = '0; ew = 1'b0;
        if (g_c) begin ea = c_addr; ed = c_wdata; ew = c_we; end
        else if (g_h) begin ea = h_addr; ed = h_wdata; ew = h_we; end
        chk({tag, ".c_gnt"}, 32'(c_gnt), 32'(g_c));
        chk({tag, ".h_gnt"}, 32'(h_gnt), 32'(g_h));
        chk({tag, ".m_we"}, 32'(m_we), 32'(ew));
        chk({tag, ".m_addr"}, 32'(m_addr), 32'(ea));
        chk({tag, ".m_wdata"}, 32'(m_wdata), 32'(ed));
        chk({tag, ".c_rvalid"}, 32'(c_rvalid), 32'(pend_v && !pend_host && !reset));
        chk({tag, ".h_rvalid"}, 32'(h_rvalid), 32'(pend_v && pend_host && !reset));
        if (pend_v && !reset) begin
            if (pend_host) chk({tag, ".h_rdata"}, 32'(h_rdata), 32'(pend_data));
            else           chk({tag, ".c_rdata"}, 32'(c_rdata), 32'(pend_data));
        end
    endtask

    // Advance one clock, applying the model's view of the cycle just checked.
    task automatic tick();
        if (reset) begin
            pend_v = 0;
            waits  = 0;
        end else begin
            pend_v = 0;
            if (g_c && !c_we) begin pend_v = 1; pend_host = 0; pend_data = mm[c_addr]; end
            if (g_h && !h_we) begin pend_v = 1; pend_host = 1; pend_data = mm[h_addr]; end
            if (g_c && c_we) mm[c_addr] = c_wdata;
            if (g_h && h_we) mm[h_addr] = h_wdata;
            if (h_req && !g_h) waits = (waits < MW) ? waits + 1 : MW;
            else               waits = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic step(input string tag);
        #1;
        mcheck(tag);
        tick();
    endtask

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          hr, hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          egc, egh, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic          ecv, ehv;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{1, 0, 12'h010, 16'h0,    0, 0, 12'h0,   16'h0,    1, 0, 0, 12'h010, 16'h0,    0, 0, 16'h0};
        vt[1]  = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    1, 0, 16'h1234};
        vt[2]  = '{0, 0, 12'h0,   16'h0,    1, 1, 12'h020, 16'hBEEF, 0, 1, 1, 12'h020, 16'hBEEF, 0, 0, 16'h0};
        vt[3]  = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    0, 0, 16'h0};
        vt[4]  = '{1, 0, 12'h020, 16'h0,    0, 0, 12'h0,   16'h0,    1, 0, 0, 12'h020, 16'h0,    0, 0, 16'h0};
        vt[5]  = '{0, 0, 12'h0,   16'h0,    1, 0, 12'h010, 16'h0,    0, 1, 0, 12'h010, 16'h0,    1, 0, 16'hBEEF};
        vt[6]  = '{1, 0, 12'h020, 16'h0,    0, 0, 12'h0,   16'h0,    1, 0, 0, 12'h020, 16'h0,    0, 1, 16'h1234};
        vt[7]  = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    1, 0, 16'hBEEF};
        vt[8]  = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    0, 0, 16'h0};
        vt[9]  = '{1, 1, 12'h030, 16'h5555, 1, 1, 12'h040, 16'h6666, 1, 0, 1, 12'h030, 16'h5555, 0, 0, 16'h0};
        vt[10] = '{0, 0, 12'h0,   16'h0,    1, 1, 12'h040, 16'h6666, 0, 1, 1, 12'h040, 16'h6666, 0, 0, 16'h0};
        vt[11] = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    0, 0, 16'h0};
        vt[12] = '{1, 0, 12'h030, 16'h0,    0, 0, 12'h0,   16'h0,    1, 0, 0, 12'h030, 16'h0,    0, 0, 16'h0};
        vt[13] = '{0, 0, 12'h0,   16'h0,    1, 0, 12'h040, 16'h0,    0, 1, 0, 12'h040, 16'h0,    1, 0, 16'h5555};
        vt[14] = '{0, 0, 12'h0,   16'h0,    0, 0, 12'h0,   16'h0,    0, 0, 0, 12'h0,   16'h0,    0, 1, 16'h6666};

        for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; mm[i] = '0; end
        mem[12'h010] = 16'h1234;
        mm[12'h010]  = 16'h1234;
        waits = 0; pend_v = 0; pend_host = 0; pend_data = '0; g_c = 0; g_h = 0;

        // Reset state with both requesters active.
        reset = 1'b1;
        drive(1, 1, 12'h5, 16'h1, 1, 1, 12'h6, 16'h2);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst.c_gnt", 32'(c_gnt), 32'h0);
        chk("rst.h_gnt", 32'(h_gnt), 32'h0);
        chk("rst.m_we", 32'(m_we), 32'h0);
        chk("rst.c_rvalid", 32'(c_rvalid), 32'h0);
        chk("rst.h_rvalid", 32'(h_rvalid), 32'h0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].hr, vt[i].hw, vt[i].ha, vt[i].hd);
            #1;
            chk($sformatf("vec%0d.c_gnt", i), 32'(c_gnt), 32'(vt[i].egc));
            chk($sformatf("vec%0d.h_gnt", i), 32'(h_gnt), 32'(vt[i].egh));
            chk($sformatf("vec%0d.m_we", i), 32'(m_we), 32'(vt[i].ewe));
            chk($sformatf("vec%0d.m_addr", i), 32'(m_addr), 32'(vt[i].ea));
            chk($sformatf("vec%0d.m_wdata", i), 32'(m_wdata), 32'(vt[i].ewd));
            chk($sformatf("vec%0d.c_rvalid", i), 32'(c_rvalid), 32'(vt[i].ecv));
            chk($sformatf("vec%0d.h_rvalid", i), 32'(h_rvalid), 32'(vt[i].ehv));
            if (vt[i].ecv) chk($sformatf("vec%0d.c_rdata", i), 32'(c_rdata), 32'(vt[i].erd));
            if (vt[i].ehv) chk($sformatf("vec%0d.h_rdata", i), 32'(h_rdata), 32'(vt[i].erd));
            mcheck($sformatf("vec%0d.model", i));
            tick();
        end

        // Continuous contention: host gets every 5th slot.
        drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("starve%0d.h_gnt", i), 32'(h_gnt), 32'(i % 5 == 4));
            mcheck($sformatf("starve%0d", i));
            tick();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step("starve_end");

        // Host waits 3 cycles, drops, then contention restarts from zero.
        drive(1, 0, 12'h011, '0, 1, 0, 12'h021, '0);
        for (int i = 0; i < 3; i++) step($sformatf("drop_wait%0d", i));
        drive(1, 0, 12'h011, '0, 0, 0, '0, '0);
        step("drop_gap");
        drive(1, 0, 12'h011, '0, 1, 0, 12'h021, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("drop_after%0d.c_gnt", i), 32'(c_gnt), 32'(i < 4));
            mcheck($sformatf("drop_after%0d", i));
            tick();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step("drop_end");

        // Reset lands on a granted core read.
        drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
        #1;
        chk("rstrd.pre_gnt", 32'(c_gnt), 32'h1);
        reset = 1'b1;
        c_we  = 1'b1;
        #1;
        chk("rstrd.c_gnt", 32'(c_gnt), 32'h0);
        chk("rstrd.m_we", 32'(m_we), 32'h0);
        chk("rstrd.c_rvalid", 32'(c_rvalid), 32'h0);
        c_we = 1'b0;
        tick();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        reset = 1'b0;
        step("rstrd.release");
        drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rstrd.cont%0d.h_gnt", i), 32'(h_gnt), 32'(i == 4));
            mcheck($sformatf("rstrd.cont%0d", i));
            tick();
        end

        // Random traffic on a small address window to exercise reuse.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            step($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
